// File: rtl/symm_orth_pkg.sv
// Shared definitions for the symmetric-orthogonalisation sequencer:
// Q13 element format, 4x4 bus packing and FSM state encoding.
package symm_orth_pkg;

  localparam int unsigned FRAC_W  = 13;
  localparam int unsigned ELEM_W  = 2 * FRAC_W;
  localparam int unsigned N_ELEM  = 16;
  localparam int unsigned BUS_W   = N_ELEM * ELEM_W;
  localparam int unsigned SUM_W   = ELEM_W + 2;
  localparam int unsigned DELTA_W = ELEM_W + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_UPD,
    S_DONE
  } state_e;

  // Linear element index of row r, column c (both 1..4).
  function automatic int unsigned elem_idx(input int unsigned r, input int unsigned c);
    return 4 * (r - 1) + (c - 1);
  endfunction

  // LSB position of a linear element index on the 416-bit buses.
  function automatic int unsigned elem_lsb(input int unsigned idx);
    return idx * ELEM_W;
  endfunction

endpackage

// File: rtl/symm_orth_upd.sv
// Combinational update for all 16 elements: n = sat(1.5*W - R),
// per-element |n - W| and the max-reduction over the lanes.
module symm_orth_upd
  import symm_orth_pkg::*;
(
  input  logic [BUS_W-1:0]   w_i,
  input  logic [BUS_W-1:0]   r_i,
  output logic [BUS_W-1:0]   n_o,
  output logic [DELTA_W-1:0] dmax_o
);

  localparam logic signed [SUM_W-1:0] SAT_HI = SUM_W'((2 ** (ELEM_W - 1)) - 1);
  localparam logic signed [SUM_W-1:0] SAT_LO = -SUM_W'(2 ** (ELEM_W - 1));

  logic [DELTA_W-1:0] d   [N_ELEM];
  logic [DELTA_W-1:0] lvl [2*N_ELEM-1];

  for (genvar r = 1; r <= 4; r++) begin : g_row
    for (genvar c = 1; c <= 4; c++) begin : g_col
      localparam int unsigned E   = elem_idx(r, c);
      localparam int unsigned LSB = elem_lsb(E);

      logic signed [SUM_W-1:0] w_s, r_s, s_s, n_s, diff_s;

      assign w_s = SUM_W'(signed'(w_i[LSB +: ELEM_W]));
      assign r_s = SUM_W'(signed'(r_i[LSB +: ELEM_W]));
      assign s_s = w_s + (w_s >>> 1) - r_s;

      // Clamp the widened sum back into the 26-bit signed element range
      always_comb begin
        n_s = s_s;
        if (s_s > SAT_HI) n_s = SAT_HI;
        else if (s_s < SAT_LO) n_s = SAT_LO;
      end

      assign diff_s = n_s - w_s;
      assign d[E]   = diff_s[SUM_W-1] ? DELTA_W'(-diff_s) : DELTA_W'(diff_s);
      assign n_o[LSB +: ELEM_W] = n_s[ELEM_W-1:0];
    end
  end

  // Heap-ordered max tree: leaves at 15..30, root at 0
  always_comb begin
    for (int unsigned i = 0; i < N_ELEM; i++) begin
      lvl[N_ELEM-1+i] = d[i];
    end
    for (int unsigned i = N_ELEM - 1; i > 0; i--) begin
      lvl[i-1] = (lvl[2*i-1] > lvl[2*i]) ? lvl[2*i-1] : lvl[2*i];
    end
  end

  assign dmax_o = lvl[0];

endmodule

// File: rtl/symm_orth_ctrl.sv
// Iteration sequencer for symmetric orthogonalisation:
// W <- 1.5*W - 0.5*W*W^T*W until max |delta| <= TOL or MAX_ITER reached.
module symm_orth_ctrl
  import symm_orth_pkg::*;
#(
  parameter int unsigned MAX_ITER = 16,
  parameter int unsigned TOL      = 8,
  parameter int unsigned PRESHIFT = 0
) (
  input  logic             clk_orth,
  input  logic             rst_orth,
  input  logic             start,
  input  logic [BUS_W-1:0] w_in,
  output logic [BUS_W-1:0] mul_w,
  output logic             en_mul3,
  input  logic [BUS_W-1:0] mul_res,
  output logic [BUS_W-1:0] w_out,
  output logic             busy,
  output logic             done,
  output logic             converged,
  output logic [7:0]       iter_cnt
);

  localparam logic [DELTA_W-1:0] TOL_V = DELTA_W'(TOL);
  localparam logic [7:0]         CAP_V = 8'(MAX_ITER);

  state_e             state_q;
  logic [BUS_W-1:0]   w_q;
  logic               en_q, busy_q, done_q, conv_q;
  logic [7:0]         iter_q;

  logic [BUS_W-1:0]   w_load_d;
  logic [BUS_W-1:0]   w_upd_d;
  logic [DELTA_W-1:0] dmax_d;
  logic [7:0]         iter_d;

  // Sign-preserving pre-scale of the incoming matrix
  always_comb begin
    w_load_d = '0;
    for (int unsigned e = 0; e < N_ELEM; e++) begin
      w_load_d[elem_lsb(e) +: ELEM_W] =
        ELEM_W'(signed'(w_in[elem_lsb(e) +: ELEM_W]) >>> PRESHIFT);
    end
  end

  symm_orth_upd u_upd (
    .w_i    (w_q),
    .r_i    (mul_res),
    .n_o    (w_upd_d),
    .dmax_o (dmax_d)
  );

  assign iter_d = iter_q + 8'd1;

  // Sequencer FSM; all outputs are registered and set on entry to a state
  always_ff @(posedge clk_orth) begin
    if (rst_orth) begin
      state_q <= S_IDLE;
      w_q     <= '0;
      en_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      conv_q  <= 1'b0;
      iter_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            w_q     <= w_load_d;
            iter_q  <= '0;
            conv_q  <= 1'b0;
            en_q    <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= S_MUL;
          end
        end
        S_MUL: begin
          en_q    <= 1'b0;
          state_q <= S_UPD;
        end
        S_UPD: begin
          w_q    <= w_upd_d;
          iter_q <= iter_d;
          if (dmax_d <= TOL_V) begin
            conv_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else if (iter_d == CAP_V) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            en_q    <= 1'b1;
            state_q <= S_MUL;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign mul_w     = w_q;
  assign w_out     = w_q;
  assign en_mul3   = en_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign converged = conv_q;
  assign iter_cnt  = iter_q;

endmodule
